// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - ROM-driven note sequencer for piezo and LED jingles
// Optional MELODY_SEQUENCER_LOOP_EN adds a loop input that replays the song at its end.
module melody_sequencer #(
  parameter int TICK_DIV  = 5000000,
  parameter int NOTE_W    = 4,
  parameter int ADDR_W    = 5,
  parameter int SEL_W     = 1,
  parameter int SONG_LEN  = 27,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SEL_W-1:0]        song_sel,
  input  logic                    stop,
`ifdef MELODY_SEQUENCER_LOOP_EN
  input  logic                    loop,
`endif
  output logic [SEL_W+ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0]       rom_data,
  output logic [NOTE_W-1:0]       note_out,
  output logic [NOTE_W-1:0]       led_out,
  output logic                    busy,
  output logic                    done
);

  localparam int TCK_W    = $clog2(TICK_DIV);
  localparam int SLOT_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int SLOT_W   = $clog2(SLOT_MAX + 1);
  localparam logic [TCK_W-1:0]  TICK_LAST = TCK_W'(TICK_DIV - 1);
  localparam logic [SLOT_W-1:0] ON_LAST   = SLOT_W'(ON_TICKS - 1);
  localparam logic [SLOT_W-1:0] OFF_LAST  = SLOT_W'(OFF_TICKS - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, NOTE_ON, NOTE_OFF} state_t;

  state_t              state_q, state_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]    song_q, song_d;
  logic [TCK_W-1:0]    tick_q, tick_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tick;
  logic                loop_en;

`ifdef MELODY_SEQUENCER_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  always_comb begin
    tick    = (tick_q == TICK_LAST);
    state_d = state_q;
    note_d  = note_q;
    idx_d   = idx_q;
    song_d  = song_q;
    tick_d  = tick_q;
    slot_d  = slot_q;
    done_d  = 1'b0;

    if (state_q == NOTE_ON || state_q == NOTE_OFF) begin
      tick_d = tick ? '0 : tick_q + 1'b1;
      if (tick) slot_d = slot_q + 1'b1;
    end

    case (state_q)
      LOAD: begin
        note_d  = rom_data;
        tick_d  = '0;
        slot_d  = '0;
        state_d = NOTE_ON;
      end
      NOTE_ON: begin
        if (tick && slot_q == ON_LAST) begin
          note_d  = '0;
          slot_d  = '0;
          state_d = NOTE_OFF;
        end
      end
      NOTE_OFF: begin
        if (tick && slot_q == OFF_LAST) begin
          slot_d  = '0;
          state_d = LOAD;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (!loop_en) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Abort beats restart, and both suppress the natural-end done pulse.
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      note_d  = '0;
      idx_d   = '0;
      tick_d  = '0;
      slot_d  = '0;
      done_d  = 1'b0;
    end else if (start && !stop) begin
      state_d = LOAD;
      song_d  = song_sel;
      idx_d   = '0;
      note_d  = '0;
      tick_d  = '0;
      slot_d  = '0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      note_q  <= '0;
      idx_q   <= '0;
      song_q  <= '0;
      tick_q  <= '0;
      slot_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      idx_q   <= idx_d;
      song_q  <= song_d;
      tick_q  <= tick_d;
      slot_q  <= slot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr = {song_q, idx_q};
  assign note_out = note_q;
  assign led_out  = note_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
